// File: rtl/cache_ctrl.sv
// ---------------------------------------------------------------------------
// cache_ctrl
//
// Sequencer between a single CPU load/store requester, a fully associative
// cache and the backing main memory.
//   - Reads look the cache up. A hit returns the cached word. A miss fetches
//     the word from memory, fills the cache, then returns it.
//   - Writes go through to memory first, then allocate/update the cache.
//   - A memory access that sees no mem_ack for MEM_TIMEOUT cycles is aborted.
//     The request then completes with cpu_err=1. MEM_TIMEOUT=0 disables this.
//
// Ports
//   clk, rst_n      clock (posedge) and asynchronous active-low reset
//   cpu_req/cpu_we/cpu_addr/cpu_wdata   request, sampled when accepted
//   cpu_ready       idle and accepting a request
//   cpu_done        one-cycle completion pulse
//   cpu_err         with cpu_done: 1 = memory timeout abort
//   cpu_rdata       read data, valid with cpu_done for reads
//   ctl_addr        latched request address (to cache and memory)
//   ctl_wdata       fill / write data (to cache and memory)
//   c_lookup        one-cycle cache lookup strobe
//   c_hit/c_rdata   cache hit and data, valid the cycle after c_lookup
//   c_we            one-cycle cache write/fill strobe
//   mem_req/mem_we  memory request and write qualifier
//   mem_ack         memory completion; read data valid in the same cycle
//   mem_rdata       memory read data
//
// Optional build macro: CACHE_CTRL_STATS_EN
//   When it is defined, the block adds the saturating outputs hit_count[15:0]
//   and miss_count[15:0]. They count read hits and read misses in CHECK.
//   When it is undefined, neither the ports nor the counters exist.
// ---------------------------------------------------------------------------
module cache_ctrl #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ready,
    output logic                  cpu_done,
    output logic                  cpu_err,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic [ADDR_WIDTH-1:0] ctl_addr,
    output logic [DATA_WIDTH-1:0] ctl_wdata,
    output logic                  c_lookup,
    input  logic                  c_hit,
    input  logic [DATA_WIDTH-1:0] c_rdata,
    output logic                  c_we,
    output logic                  mem_req,
    output logic                  mem_we,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_MEM_RD = 3'd3;
    localparam logic [2:0] S_MEM_WR = 3'd4;
    localparam logic [2:0] S_FILL   = 3'd5;
    localparam logic [2:0] S_RESP   = 3'd6;

    // The counter keeps at least one bit so that MEM_TIMEOUT=0 still
    // elaborates. In that case the timeout compare is disabled by TO_EN.
    localparam int              CNT_W    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic            TO_EN    = (MEM_TIMEOUT > 0) ? 1'b1 : 1'b0;
    // Expiry is detected in the last waiting cycle, when the counter is one
    // below the limit. mem_req therefore stays high for exactly MEM_TIMEOUT
    // cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0]            state_q,     state_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic [ADDR_WIDTH-1:0] ctl_addr_q,  ctl_addr_d;
    logic [DATA_WIDTH-1:0] ctl_wdata_q, ctl_wdata_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic                  timeout_s;
    logic                  cpu_ready_q, cpu_ready_d;
    logic                  cpu_done_q,  cpu_done_d;
    logic                  cpu_err_q,   cpu_err_d;
    logic                  c_lookup_q,  c_lookup_d;
    logic                  c_we_q,      c_we_d;
    logic                  mem_req_q,   mem_req_d;
    logic                  mem_we_q,    mem_we_d;

    // Next-state, timeout counter and datapath latch logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ctl_addr_d  = ctl_addr_q;
        ctl_wdata_d = ctl_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        timeout_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // cpu_ready_q is still low in the first cycle after reset,
                // so no request is accepted in that cycle.
                if (cpu_req && cpu_ready_q) begin
                    ctl_addr_d  = cpu_addr;
                    ctl_wdata_d = cpu_wdata;
                    cpu_rdata_d = {DATA_WIDTH{1'b0}};
                    if (cpu_we) begin
                        state_d = S_MEM_WR;
                    end else begin
                        state_d = S_LOOKUP;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOOKUP: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (c_hit) begin
                    cpu_rdata_d = c_rdata;
                    state_d     = S_RESP;
                end else begin
                    state_d     = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                // mem_ack has priority over expiry when both occur in the
                // same cycle.
                if (mem_ack) begin
                    cnt_d       = {CNT_W{1'b0}};
                    ctl_wdata_d = mem_rdata;
                    cpu_rdata_d = mem_rdata;
                    state_d     = S_FILL;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    cnt_d       = {CNT_W{1'b0}};
                    cpu_rdata_d = {DATA_WIDTH{1'b0}};
                    timeout_s   = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d       = cnt_q + CNT_ONE;
                end
            end
            S_MEM_WR: begin
                if (mem_ack) begin
                    cnt_d     = {CNT_W{1'b0}};
                    state_d   = S_FILL;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    cnt_d     = {CNT_W{1'b0}};
                    timeout_s = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    cnt_d     = cnt_q + CNT_ONE;
                end
            end
            S_FILL: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output decode from the next state, so every strobe comes from a flop
    // and appears in the same cycle as the state it belongs to.
    always_comb begin
        cpu_ready_d = (state_d == S_IDLE);
        cpu_done_d  = (state_d == S_RESP);
        cpu_err_d   = (state_d == S_RESP) && timeout_s;
        c_lookup_d  = (state_d == S_LOOKUP);
        c_we_d      = (state_d == S_FILL);
        mem_req_d   = (state_d == S_MEM_RD) || (state_d == S_MEM_WR);
        mem_we_d    = (state_d == S_MEM_WR);
    end

    // State, counter, datapath and output registers. Reset also clears
    // mem_req and c_we asynchronously and drops any pending request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            ctl_addr_q  <= {ADDR_WIDTH{1'b0}};
            ctl_wdata_q <= {DATA_WIDTH{1'b0}};
            cpu_rdata_q <= {DATA_WIDTH{1'b0}};
            cpu_ready_q <= 1'b0;
            cpu_done_q  <= 1'b0;
            cpu_err_q   <= 1'b0;
            c_lookup_q  <= 1'b0;
            c_we_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ctl_addr_q  <= ctl_addr_d;
            ctl_wdata_q <= ctl_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_done_q  <= cpu_done_d;
            cpu_err_q   <= cpu_err_d;
            c_lookup_q  <= c_lookup_d;
            c_we_q      <= c_we_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign cpu_ready = cpu_ready_q;
    assign cpu_done  = cpu_done_q;
    assign cpu_err   = cpu_err_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ctl_addr  = ctl_addr_q;
    assign ctl_wdata = ctl_wdata_q;
    assign c_lookup  = c_lookup_q;
    assign c_we      = c_we_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;

`ifdef CACHE_CTRL_STATS_EN
    logic [15:0] hit_cnt_q,  hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    // Saturating read hit/miss counters, updated on the CHECK decision.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == S_CHECK) begin
            if (c_hit) begin
                if (hit_cnt_q != 16'hFFFF) begin
                    hit_cnt_d = hit_cnt_q + 16'd1;
                end else begin
                    hit_cnt_d = hit_cnt_q;
                end
            end else begin
                if (miss_cnt_q != 16'hFFFF) begin
                    miss_cnt_d = miss_cnt_q + 16'd1;
                end else begin
                    miss_cnt_d = miss_cnt_q;
                end
            end
        end else begin
            hit_cnt_d  = hit_cnt_q;
            miss_cnt_d = miss_cnt_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= 16'd0;
            miss_cnt_q <= 16'd0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_ctrl
//
// Directed bench for cache_ctrl. The bench uses two instances:
//   dut  : default MEM_TIMEOUT (64). It covers the hit, miss, write and
//          mid-operation reset sequences.
//   dut2 : MEM_TIMEOUT=4. It covers acknowledge-on-the-last-cycle and the
//          timeout abort.
// Inputs change 1 time unit after a rising edge. Outputs are checked at that
// same point, so they never change at the moment they are sampled. Pulse
// counters sampled on the falling edge record how many cycles each strobe
// stayed high.
// ---------------------------------------------------------------------------
module tb_cache_ctrl;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        cpu_req = 1'b0, cpu_req2 = 1'b0;
    logic        cpu_we = 1'b0;
    logic [11:0] cpu_addr = 12'h000;
    logic [15:0] cpu_wdata = 16'h0000;
    logic        c_hit = 1'b0;
    logic [15:0] c_rdata = 16'h0000;
    logic        mem_ack = 1'b0, mem_ack2 = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;

    logic        cpu_ready, cpu_done, cpu_err, c_lookup, c_we, mem_req, mem_we;
    logic [15:0] cpu_rdata, ctl_wdata;
    logic [11:0] ctl_addr;
    logic        cpu_ready2, cpu_done2, cpu_err2, c_lookup2, c_we2, mem_req2, mem_we2;
    logic [15:0] cpu_rdata2, ctl_wdata2;
    logic [11:0] ctl_addr2;
`ifdef CACHE_CTRL_STATS_EN
    logic [15:0] hit_count, miss_count, hit_count2, miss_count2;
`endif

    int n_pass  = 0;
    int n_total = 0;

    int n_mreq = 0, n_mwe = 0, n_cwe = 0, n_look = 0, n_done = 0;
    int n2_mreq = 0, n2_cwe = 0, n2_done = 0;
    int b_mreq, b_mwe, b_cwe, b_look, b_done, b2_mreq, b2_cwe, b2_done;

    cache_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata),
        .c_lookup(c_lookup), .c_hit(c_hit), .c_rdata(c_rdata), .c_we(c_we),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef CACHE_CTRL_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    cache_ctrl #(.MEM_TIMEOUT(4)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req2), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready2), .cpu_done(cpu_done2), .cpu_err(cpu_err2), .cpu_rdata(cpu_rdata2),
        .ctl_addr(ctl_addr2), .ctl_wdata(ctl_wdata2),
        .c_lookup(c_lookup2), .c_hit(c_hit), .c_rdata(c_rdata), .c_we(c_we2),
        .mem_req(mem_req2), .mem_we(mem_we2), .mem_ack(mem_ack2), .mem_rdata(mem_rdata)
`ifdef CACHE_CTRL_STATS_EN
        , .hit_count(hit_count2), .miss_count(miss_count2)
`endif
    );

    always #5 clk = ~clk;

    // Count the number of cycles each strobe is high.
    always @(negedge clk) begin
        if (mem_req)            n_mreq  <= n_mreq + 1;
        if (mem_req && mem_we)  n_mwe   <= n_mwe + 1;
        if (c_we)               n_cwe   <= n_cwe + 1;
        if (c_lookup)           n_look  <= n_look + 1;
        if (cpu_done)           n_done  <= n_done + 1;
        if (mem_req2)           n2_mreq <= n2_mreq + 1;
        if (c_we2)              n2_cwe  <= n2_cwe + 1;
        if (cpu_done2)          n2_done <= n2_done + 1;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chkd(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_mreq = n_mreq;   b_mwe = n_mwe;   b_cwe = n_cwe;
        b_look = n_look;   b_done = n_done;
        b2_mreq = n2_mreq; b2_cwe = n2_cwe; b2_done = n2_done;
    endtask

    initial begin
        // ---------------- reset ----------------
        #1 rst_n = 1'b0;
        #2;
        chk1("rst cpu_ready", cpu_ready, 1'b0);
        chk1("rst cpu_done",  cpu_done,  1'b0);
        chk1("rst mem_req",   mem_req,   1'b0);
        chk1("rst c_we",      c_we,      1'b0);
        chk1("rst c_lookup",  c_lookup,  1'b0);
        chkd("rst ctl_addr",  {4'h0, ctl_addr}, 16'h0000);
        #9 rst_n = 1'b1;
        step();
        chk1("ready after reset", cpu_ready, 1'b1);
        chk1("ready2 after reset", cpu_ready2, 1'b1);

        // ---------------- read hit 0x0A5 ----------------
        snap();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h0A5; mem_ack = 1'b1;
        step();                                   // LOOKUP
        chk1("hit c_lookup", c_lookup, 1'b1);
        chk1("hit ready low", cpu_ready, 1'b0);
        chkd("hit ctl_addr", {4'h0, ctl_addr}, 16'h00A5);
        cpu_req = 1'b0; c_hit = 1'b1; c_rdata = 16'hBEEF;
        step();                                   // CHECK
        chk1("hit lookup one cycle", c_lookup, 1'b0);
        chk1("hit no early done", cpu_done, 1'b0);
        step();                                   // RESP
        chk1("hit cpu_done", cpu_done, 1'b1);
        chkd("hit cpu_rdata", cpu_rdata, 16'hBEEF);
        chk1("hit cpu_err", cpu_err, 1'b0);
        mem_ack = 1'b0; c_hit = 1'b0; c_rdata = 16'h0000;
        step();                                   // IDLE
        chk1("hit done one cycle", cpu_done, 1'b0);
        chk1("hit ready back", cpu_ready, 1'b1);
        chki("hit mem_req cycles", n_mreq - b_mreq, 0);
        chki("hit lookup pulses", n_look - b_look, 1);

        // ---------------- read miss 0x100, ack in 5th cycle ----------------
        snap();
        cpu_req = 1'b1; cpu_addr = 12'h100;
        step();                                   // LOOKUP
        cpu_req = 1'b0;
        step();                                   // CHECK (c_hit=0)
        step();                                   // MEM_RD cycle 1
        chk1("miss mem_req", mem_req, 1'b1);
        chk1("miss mem_we", mem_we, 1'b0);
        step(); step(); step();                   // cycles 2..4
        chk1("miss mem_req held", mem_req, 1'b1);
        step();                                   // cycle 5
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        step();                                   // FILL
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        chk1("miss c_we", c_we, 1'b1);
        chkd("miss fill data", ctl_wdata, 16'h1234);
        chk1("miss mem_req dropped", mem_req, 1'b0);
        step();                                   // RESP
        chk1("miss cpu_done", cpu_done, 1'b1);
        chkd("miss cpu_rdata", cpu_rdata, 16'h1234);
        chk1("miss cpu_err", cpu_err, 1'b0);
        step();                                   // IDLE
        chki("miss mem_req cycles", n_mreq - b_mreq, 5);
        chki("miss mem_we cycles", n_mwe - b_mwe, 0);
        chki("miss c_we pulses", n_cwe - b_cwe, 1);

        // ---------------- write 0x200, ack first cycle, req held busy ------
        snap();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h200; cpu_wdata = 16'h5555;
        step();                                   // MEM_WR cycle 1
        chk1("wr mem_req", mem_req, 1'b1);
        chk1("wr mem_we", mem_we, 1'b1);
        chkd("wr ctl_wdata", ctl_wdata, 16'h5555);
        chkd("wr ctl_addr", {4'h0, ctl_addr}, 16'h0200);
        mem_ack = 1'b1; cpu_we = 1'b0; cpu_wdata = 16'hAAAA;
        step();                                   // FILL
        mem_ack = 1'b0;
        chk1("wr c_we", c_we, 1'b1);
        chkd("wr fill data", ctl_wdata, 16'h5555);
        chk1("wr mem_req dropped", mem_req, 1'b0);
        step();                                   // RESP
        cpu_req = 1'b0;
        chk1("wr cpu_done", cpu_done, 1'b1);
        chk1("wr cpu_err", cpu_err, 1'b0);
        step();                                   // IDLE
        chk1("wr ready back", cpu_ready, 1'b1);
        step();
        chk1("wr busy req ignored", cpu_ready, 1'b1);
        chki("wr lookup pulses", n_look - b_look, 0);
        chki("wr done pulses", n_done - b_done, 1);
        chki("wr mem_req cycles", n_mreq - b_mreq, 1);

`ifdef CACHE_CTRL_STATS_EN
        chkd("stats hit_count", hit_count, 16'd1);
        chkd("stats miss_count", miss_count, 16'd1);
`endif

        // ---------------- dut2: ack on the 4th (last) cycle ----------------
        snap();
        cpu_req2 = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h300;
        step();                                   // LOOKUP
        cpu_req2 = 1'b0;
        chk1("to2 c_lookup", c_lookup2, 1'b1);
        chkd("to2 ctl_addr", {4'h0, ctl_addr2}, 16'h0300);
        step();                                   // CHECK
        step();                                   // MEM cycle 1
        chk1("to2 mem_we", mem_we2, 1'b0);
        step(); step(); step();                   // cycle 4
        chk1("to2 mem_req c4", mem_req2, 1'b1);
        mem_ack2 = 1'b1; mem_rdata = 16'h4321;
        step();                                   // FILL
        mem_ack2 = 1'b0; mem_rdata = 16'h0000;
        chk1("ack-last c_we", c_we2, 1'b1);
        chkd("ack-last fill", ctl_wdata2, 16'h4321);
        step();                                   // RESP
        chk1("ack-last done", cpu_done2, 1'b1);
        chk1("ack-last err", cpu_err2, 1'b0);
        chkd("ack-last rdata", cpu_rdata2, 16'h4321);
        step();                                   // IDLE
        chki("ack-last mem_req cycles", n2_mreq - b2_mreq, 4);

        // ---------------- dut2: timeout, never acked ----------------
        snap();
        cpu_req2 = 1'b1; cpu_addr = 12'h301; mem_rdata = 16'h7777;
        step();                                   // LOOKUP
        cpu_req2 = 1'b0;
        step();                                   // CHECK
        step(); step(); step(); step();           // MEM cycles 1..4
        chk1("to mem_req c4", mem_req2, 1'b1);
        step();                                   // RESP
        chk1("to mem_req dropped", mem_req2, 1'b0);
        chk1("to done", cpu_done2, 1'b1);
        chk1("to err", cpu_err2, 1'b1);
        chkd("to rdata zero", cpu_rdata2, 16'h0000);
        step();                                   // IDLE
        chk1("to err cleared", cpu_err2, 1'b0);
        chk1("to ready back", cpu_ready2, 1'b1);
        chki("to mem_req cycles", n2_mreq - b2_mreq, 4);
        chki("to no c_we", n2_cwe - b2_cwe, 0);
        chki("to done pulses", n2_done - b2_done, 1);
        mem_rdata = 16'h0000;

        // ---------------- reset in the middle of MEM_RD ----------------
        snap();
        cpu_req = 1'b1; cpu_addr = 12'h400;
        step();                                   // LOOKUP
        cpu_req = 1'b0;
        step();                                   // CHECK
        step();                                   // MEM_RD cycle 1
        chk1("mid mem_req before", mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("mid mem_req async drop", mem_req, 1'b0);
        chk1("mid ready in reset", cpu_ready, 1'b0);
        cpu_req = 1'b1;
        step();
        chk1("mid still not ready", cpu_ready, 1'b0);
        rst_n = 1'b1; cpu_req = 1'b0;
        step();
        chk1("mid ready after release", cpu_ready, 1'b1);
        chk1("mid no mem_req", mem_req, 1'b0);
        chki("mid no cpu_done", n_done - b_done, 0);
`ifdef CACHE_CTRL_STATS_EN
        chkd("stats hit reset", hit_count, 16'd0);
        chkd("stats miss reset", miss_count, 16'd0);
`endif
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
